instr_fetch_unit: RTL and testbench

Instruction fetch stage of the 16-bit Harvard processor, directly upstream of the decode stage. It holds the program counter and issues word-addressed reads to instruction memory over a valid/ready request channel. It buffers the in-order 32-bit responses in a small FIFO and presents each instruction with its PC to decode over a valid/ready handshake. Branch/jump redirects from later stages flush the FIFO and discard responses still in flight.

---
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, response FIFO to decode.
// Redirects flush the FIFO and mark every still-outstanding response for discard.
module instr_fetch_unit #(
    parameter int              AW       = 16,
    parameter int              IW       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [IW-1:0] imem_rsp_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [IW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int FW = $clog2(2 * DEPTH) + 1;

    logic [AW-1:0] pc_r, rsp_pc_r, pc_nxt_s, rsp_pc_nxt_s;
    logic [FW-1:0] inflight_r, drop_r, inflight_nxt_s, drop_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic [PW-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [IW-1:0] fifo_instr_r [DEPTH];
    logic [AW-1:0] fifo_pc_r    [DEPTH];
    logic          credit_s, acc_s, rsp_s, drop_hit_s, wr_s, pop_s;

    // Credits cover both buffered entries and outstanding requests, so the FIFO cannot overflow.
    assign credit_s       = (FW'(count_r) + inflight_r) < FW'(DEPTH);
    assign imem_req_valid = rst_n && !redirect_valid && credit_s;
    assign imem_addr      = pc_r;
    assign dec_valid      = (count_r != {CW{1'b0}});

    assign acc_s      = imem_req_valid && imem_req_ready;
    assign rsp_s      = imem_rsp_valid && (inflight_r != {FW{1'b0}});
    assign drop_hit_s = rsp_s && (drop_r != {FW{1'b0}});
    assign wr_s       = rsp_s && !drop_hit_s && !redirect_valid;
    assign pop_s      = dec_valid && dec_ready && !redirect_valid;

    // Head entry presented to decode, zeroed when empty.
    always_comb begin
        dec_instr = {IW{1'b0}};
        dec_pc    = {AW{1'b0}};
        if (dec_valid) begin
            dec_instr = fifo_instr_r[head_r];
            dec_pc    = fifo_pc_r[head_r];
        end else begin
            dec_instr = {IW{1'b0}};
            dec_pc    = {AW{1'b0}};
        end
    end

    // Next-state for PCs, counters and pointers; redirect overrides everything.
    always_comb begin
        pc_nxt_s       = pc_r;
        rsp_pc_nxt_s   = rsp_pc_r;
        inflight_nxt_s = inflight_r + FW'(acc_s) - FW'(rsp_s);
        drop_nxt_s     = drop_r;
        count_nxt_s    = count_r;
        head_nxt_s     = head_r;
        tail_nxt_s     = tail_r;
        if (redirect_valid) begin
            pc_nxt_s     = redirect_pc;
            rsp_pc_nxt_s = redirect_pc;
            drop_nxt_s   = (inflight_r - FW'(rsp_s)) + (drop_r - FW'(drop_hit_s));
            count_nxt_s  = {CW{1'b0}};
            head_nxt_s   = {PW{1'b0}};
            tail_nxt_s   = {PW{1'b0}};
        end else begin
            drop_nxt_s  = drop_r - FW'(drop_hit_s);
            count_nxt_s = count_r + CW'(wr_s) - CW'(pop_s);
            if (acc_s) begin
                pc_nxt_s = pc_r + AW'(1);
            end else begin
                pc_nxt_s = pc_r;
            end
            if (wr_s) begin
                tail_nxt_s   = tail_r + PW'(1);
                rsp_pc_nxt_s = rsp_pc_r + AW'(1);
            end else begin
                tail_nxt_s   = tail_r;
                rsp_pc_nxt_s = rsp_pc_r;
            end
            if (pop_s) begin
                head_nxt_s = head_r + PW'(1);
            end else begin
                head_nxt_s = head_r;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            rsp_pc_r   <= RESET_PC;
            inflight_r <= {FW{1'b0}};
            drop_r     <= {FW{1'b0}};
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
        end else begin
            pc_r       <= pc_nxt_s;
            rsp_pc_r   <= rsp_pc_nxt_s;
            inflight_r <= inflight_nxt_s;
            drop_r     <= drop_nxt_s;
            count_r    <= count_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
        end
    end

    // FIFO storage; entries are qualified by count, cleared on reset for determinism.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr_r[i] <= {IW{1'b0}};
                fifo_pc_r[i]    <= {AW{1'b0}};
            end
        end else if (wr_s) begin
            fifo_instr_r[tail_r] <= imem_rsp_data;
            fifo_pc_r[tail_r]    <= rsp_pc_r;
        end else begin
            fifo_instr_r[tail_r] <= fifo_instr_r[tail_r];
            fifo_pc_r[tail_r]    <= fifo_pc_r[tail_r];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-configurable in-order imem model.
// A second instance with RESET_PC=0xFFFE shares all inputs to exercise PC wrap-around.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [15:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0000_0000;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        dec_valid, dec_ready;
    logic [31:0] dec_instr;
    logic [15:0] dec_pc;
    logic        w_req_valid, w_dec_valid;
    logic [15:0] w_addr, w_dec_pc;
    logic [31:0] w_dec_instr;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;
    int acc_cnt  = 0;

    typedef struct {
        logic [15:0] a;
        int          due;
    } req_t;
    req_t q[$];

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc)
    );

    instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(w_dec_valid), .dec_ready(dec_ready), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory: accepted address returns as 0xA000_0000+addr, lat cycles after accept.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            q.push_back('{imem_addr, cyc + lat - 1});
            acc_cnt = acc_cnt + 1;
        end
        #1;
        if (rst_n && q.size() > 0 && q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hA000_0000 + {16'h0000, q[0].a};
            void'(q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0000_0000;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        acc_cnt = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", imem_addr); end
        n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dec_valid: got %b expected 0", dec_valid); end
        n_checks++; if (dec_instr !== 32'h0 || dec_pc !== 16'h0) begin n_fail++; $display("FAIL rst_dec_data: got %h/%h expected 0/0", dec_instr, dec_pc); end
        n_checks++; if (w_addr !== 16'hFFFE) begin n_fail++; $display("FAIL rst_addr_wrap: got %h expected fffe", w_addr); end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        lat = 1;
        dec_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_req: got %b/%h expected 1/0000", imem_req_valid, imem_addr); end
        n_checks++; if (w_req_valid !== 1'b1 || w_addr !== 16'hFFFE) begin n_fail++; $display("FAIL first_req_wrap: got %b/%h expected 1/fffe", w_req_valid, w_addr); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #2;
            n_checks++; if (imem_addr !== 16'(k)) begin n_fail++; $display("FAIL stream_addr: got %h expected %h", imem_addr, 16'(k)); end
            if (k == 1) begin
                n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b expected 0", dec_valid); end
            end else begin
                e = 16'(k - 2);
                n_checks++; if (dec_valid !== 1'b1 || dec_pc !== e) begin n_fail++; $display("FAIL stream_pc: got %b/%h expected 1/%h", dec_valid, dec_pc, e); end
                n_checks++; if (dec_instr !== 32'hA000_0000 + {16'h0, e}) begin n_fail++; $display("FAIL stream_instr: got %h expected %h", dec_instr, 32'hA000_0000 + {16'h0, e}); end
                e = 16'hFFFE + 16'(k - 2);
                n_checks++; if (w_dec_valid !== 1'b1 || w_dec_pc !== e) begin n_fail++; $display("FAIL wrap_pc: got %b/%h expected 1/%h", w_dec_valid, w_dec_pc, e); end
            end
        end
    endtask

    task automatic test_backpressure();
        lat = 1;
        dec_ready = 1'b0;
        do_reset();
        repeat (8) @(posedge clk);
        #2;
        n_checks++; if (acc_cnt !== 4) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 4", acc_cnt); end
        n_checks++; if (imem_req_valid !== 1'b0 || dut.count_r !== 3'd4) begin n_fail++; $display("FAIL bp_full: got %b/%0d expected 0/4", imem_req_valid, dut.count_r); end
        n_checks++; if (imem_addr !== 16'h0004) begin n_fail++; $display("FAIL bp_addr_hold: got %h expected 0004", imem_addr); end
        @(negedge clk);
        dec_ready = 1'b1;
        #1;
        for (int k = 0; k <= 4; k++) begin
            n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 16'(k)) begin n_fail++; $display("FAIL bp_drain_pc: got %b/%h expected 1/%h", dec_valid, dec_pc, 16'(k)); end
            @(posedge clk);
            #2;
            if (k == 0) begin
                n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0004) begin n_fail++; $display("FAIL bp_resume: got %b/%h expected 1/0004", imem_req_valid, imem_addr); end
            end
        end
    endtask

    task automatic wait_first(input logic [15:0] exp_pc, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (dec_valid === 1'b1) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL %s_timeout: got no dec_valid expected dec_pc %h", tag, exp_pc); end
        n_checks++; if (dec_pc !== exp_pc || dec_instr !== 32'hA000_0000 + {16'h0, exp_pc}) begin n_fail++; $display("FAIL %s_first: got %h/%h expected %h/%h", tag, dec_pc, dec_instr, exp_pc, 32'hA000_0000 + {16'h0, exp_pc}); end
    endtask

    task automatic test_redirect();
        lat = 3;
        dec_ready = 1'b1;
        do_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || dut.inflight_r !== 4'd2) begin n_fail++; $display("FAIL rd_cycle: got %b/%0d expected 0/2", imem_req_valid, dut.inflight_r); end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        #1;
        n_checks++; if (dec_valid !== 1'b0 || dut.drop_r !== 4'd2) begin n_fail++; $display("FAIL rd_after: got %b/%0d expected 0/2", dec_valid, dut.drop_r); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++; $display("FAIL rd_new_req: got %b/%h expected 1/0040", imem_req_valid, imem_addr); end
        wait_first(16'h0040, "rd");
    endtask

    task automatic test_simultaneous();
        lat = 3;
        dec_ready = 1'b1;
        do_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++; if (dec_valid !== 1'b1 || imem_rsp_valid !== 1'b1 || dut.inflight_r !== 4'd3) begin n_fail++; $display("FAIL sim_pre: got %b/%b/%0d expected 1/1/3", dec_valid, imem_rsp_valid, dut.inflight_r); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        #1;
        n_checks++; if (dec_valid !== 1'b0 || dut.count_r !== 3'd0) begin n_fail++; $display("FAIL sim_empty: got %b/%0d expected 0/0", dec_valid, dut.count_r); end
        n_checks++; if (dut.drop_r !== 4'd2 || dut.inflight_r !== 4'd2) begin n_fail++; $display("FAIL sim_drop: got %0d/%0d expected 2/2", dut.drop_r, dut.inflight_r); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0080) begin n_fail++; $display("FAIL sim_req: got %b/%h expected 1/0080", imem_req_valid, imem_addr); end
        wait_first(16'h0080, "sim");
    endtask

    task automatic test_reset_midop();
        lat = 1;
        dec_ready = 1'b0;
        do_reset();
        repeat (4) @(posedge clk);
        #3;
        n_checks++; if (dut.count_r !== 3'd3 || dut.inflight_r !== 4'd1) begin n_fail++; $display("FAIL mid_pre: got %0d/%0d expected 3/1", dut.count_r, dut.inflight_r); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %b/%b expected 0/0", dec_valid, imem_req_valid); end
        n_checks++; if (imem_addr !== 16'h0000 || dec_instr !== 32'h0) begin n_fail++; $display("FAIL mid_async_data: got %h/%h expected 0000/0", imem_addr, dec_instr); end
        dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL mid_restart: got %b/%h expected 1/0000", imem_req_valid, imem_addr); end
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (dec_valid !== 1'b1 || dec_pc !== 16'h0000 || dec_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL mid_first: got %b/%h/%h expected 1/0000/a0000000", dec_valid, dec_pc, dec_instr); end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        dec_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_simultaneous();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
